// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - EX-stage branch resolution against queued fetch predictions.
// Drives BTB updates, front-end redirects and a saturating mispredict counter.
module branch_resolve #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fq_push,
  input  logic        fq_pred_taken,
  input  logic [31:0] fq_pred_target,
  output logic        fq_full,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic        btb_update,
  output logic [31:0] btb_pc,
  output logic [31:0] btb_target,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [15:0] mispredict_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [DEPTH-1:0]        mem_taken_q, mem_taken_d;
  logic [DEPTH-1:0][31:0]  mem_target_q, mem_target_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]             count_q, count_d;
  logic                    btb_update_q, btb_update_d;
  logic [31:0]             btb_pc_q, btb_pc_d, btb_target_q, btb_target_d;
  logic                    redirect_q, redirect_d;
  logic [31:0]             redirect_pc_q, redirect_pc_d;
  logic [15:0]             cnt_q, cnt_d;

  logic        head_taken;
  logic [31:0] head_target;
  logic        mispredict, pop, push_ok;

  always_comb begin
    // An empty queue reads as a not-taken prediction.
    head_taken  = (count_q != '0) && mem_taken_q[rd_ptr_q];
    head_target = mem_target_q[rd_ptr_q];
    mispredict  = ex_valid && (ex_taken ? (!head_taken || (head_target != ex_target))
                                        : head_taken);
    pop         = ex_valid && (count_q != '0);
    push_ok     = fq_push && !mispredict && ((count_q < CNT_FULL) || pop);

    mem_taken_d  = mem_taken_q;
    mem_target_d = mem_target_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;

    if (mispredict) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_taken_d[wr_ptr_q]  = fq_pred_taken;
        mem_target_d[wr_ptr_q] = fq_pred_target;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push_ok && !pop)      count_d = count_q + CNT_ONE;
      else if (!push_ok && pop) count_d = count_q - CNT_ONE;
    end

    btb_update_d  = ex_valid && ex_taken;
    btb_pc_d      = btb_update_d ? ex_pc : btb_pc_q;
    btb_target_d  = btb_update_d ? ex_target : btb_target_q;
    redirect_d    = mispredict;
    redirect_pc_d = redirect_pc_q;
    if (mispredict) redirect_pc_d = ex_taken ? ex_target : (ex_pc + 32'd4);
    cnt_d = (mispredict && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_taken_q   <= '0;
      mem_target_q  <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      btb_update_q  <= 1'b0;
      btb_pc_q      <= '0;
      btb_target_q  <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      cnt_q         <= '0;
    end else begin
      mem_taken_q   <= mem_taken_d;
      mem_target_q  <= mem_target_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      btb_update_q  <= btb_update_d;
      btb_pc_q      <= btb_pc_d;
      btb_target_q  <= btb_target_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      cnt_q         <= cnt_d;
    end
  end

  assign fq_full        = (count_q == CNT_FULL);
  assign btb_update     = btb_update_q;
  assign btb_pc         = btb_pc_q;
  assign btb_target     = btb_target_q;
  assign redirect       = redirect_q;
  assign redirect_pc    = redirect_pc_q;
  assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - Randomized and directed bench for branch_resolve.
// Reference model: a prediction queue plus the resolution rules in plain arithmetic.
module tb_branch_resolve;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } pred_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fq_push = 1'b0, fq_pred_taken = 1'b0;
  logic [31:0] fq_pred_target = '0;
  logic        fq_full;
  logic        ex_valid = 1'b0, ex_taken = 1'b0;
  logic [31:0] ex_pc = '0, ex_target = '0;
  logic        btb_update, redirect;
  logic [31:0] btb_pc, btb_target, redirect_pc;
  logic [15:0] mispredict_cnt;

  int n_pass = 0;
  int n_total = 0;

  pred_t       mq[$];
  logic        exp_btb_update, exp_redirect;
  logic [31:0] exp_btb_pc, exp_btb_target, exp_redirect_pc;
  int          exp_cnt;
  logic [15:0] exp_cnt16;

  always #5 clk = ~clk;

  branch_resolve #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .fq_push(fq_push), .fq_pred_taken(fq_pred_taken), .fq_pred_target(fq_pred_target),
    .fq_full(fq_full),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .btb_update(btb_update), .btb_pc(btb_pc), .btb_target(btb_target),
    .redirect(redirect), .redirect_pc(redirect_pc), .mispredict_cnt(mispredict_cnt)
  );

  task automatic model_reset();
    mq.delete();
    exp_btb_update = 0; exp_redirect = 0;
    exp_btb_pc = 0; exp_btb_target = 0; exp_redirect_pc = 0;
    exp_cnt = 0; exp_cnt16 = 0;
  endtask

  task automatic do_cycle(input logic p, input logic ptk, input logic [31:0] ptg,
                          input logic ev, input logic [31:0] pc, input logic tk,
                          input logic [31:0] tg);
    logic ht, mis, popped;
    logic [31:0] htg;
    int size0;
    fq_push = p; fq_pred_taken = ptk; fq_pred_target = ptg;
    ex_valid = ev; ex_pc = pc; ex_taken = tk; ex_target = tg;
    @(posedge clk); #1;
    size0 = mq.size();
    ht  = (size0 > 0) ? mq[0].taken : 1'b0;
    htg = (size0 > 0) ? mq[0].target : 32'h0;
    mis = ev && (tk ? (!ht || htg != tg) : ht);
    exp_btb_update = ev && tk;
    if (ev && tk) begin exp_btb_pc = pc; exp_btb_target = tg; end
    exp_redirect = mis;
    if (mis) exp_redirect_pc = tk ? tg : pc + 32'd4;
    if (mis) begin
      mq.delete();
      if (exp_cnt < 65535) exp_cnt = exp_cnt + 1;
    end else begin
      popped = ev && (size0 > 0);
      if (popped) void'(mq.pop_front());
      if (p && (size0 < 4 || popped)) mq.push_back('{ptk, ptg});
    end
    exp_cnt16 = exp_cnt[15:0];
    fq_push = 0; ex_valid = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    model_reset();
    n_total++;
    if ({btb_update, redirect, btb_pc, btb_target, redirect_pc, mispredict_cnt, fq_full} !== '0)
      $display("FAIL reset_outputs got %h expected 0",
               {btb_update, redirect, btb_pc, btb_target, redirect_pc, mispredict_cnt, fq_full});
    else n_pass++;
  endtask

  task automatic test_correct_taken();
    do_cycle(1, 1, 32'h100, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 1, 32'h40, 1, 32'h100);
    n_total++;
    if ({btb_update, btb_pc, btb_target, redirect, mispredict_cnt, fq_full} !==
        {1'b1, 32'h40, 32'h100, 1'b0, 16'h0, 1'b0})
      $display("FAIL correct_taken got upd=%b pc=%h tgt=%h redir=%b cnt=%h full=%b expected 1 40 100 0 0 0",
               btb_update, btb_pc, btb_target, redirect, mispredict_cnt, fq_full);
    else n_pass++;
  endtask

  task automatic test_empty_mispredict();
    do_cycle(0, 0, 0, 1, 32'h80, 1, 32'h200);
    n_total++;
    if ({redirect, redirect_pc, btb_update, btb_pc, btb_target, mispredict_cnt} !==
        {1'b1, 32'h200, 1'b1, 32'h80, 32'h200, 16'h1})
      $display("FAIL empty_mispredict got redir=%b rpc=%h upd=%b pc=%h tgt=%h cnt=%h expected 1 200 1 80 200 1",
               redirect, redirect_pc, btb_update, btb_pc, btb_target, mispredict_cnt);
    else n_pass++;
    do_cycle(0, 0, 0, 0, 0, 0, 0);
    n_total++;
    if ({redirect, btb_update, redirect_pc, btb_pc} !== {1'b0, 1'b0, 32'h200, 32'h80})
      $display("FAIL pulse_hold got redir=%b upd=%b rpc=%h pc=%h expected 0 0 200 80",
               redirect, btb_update, redirect_pc, btb_pc);
    else n_pass++;
  endtask

  task automatic test_not_taken_mispredict();
    do_cycle(1, 1, 32'h300, 0, 0, 0, 0);
    do_cycle(1, 0, 0, 0, 0, 0, 0);
    do_cycle(1, 0, 0, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 1, 32'h10, 0, 0);
    n_total++;
    if ({redirect, redirect_pc, btb_update, fq_full, mispredict_cnt} !==
        {1'b1, 32'h14, 1'b0, 1'b0, 16'h2})
      $display("FAIL not_taken_mispredict got redir=%b rpc=%h upd=%b full=%b cnt=%h expected 1 14 0 0 2",
               redirect, redirect_pc, btb_update, fq_full, mispredict_cnt);
    else n_pass++;
    do_cycle(1, 0, 0, 0, 0, 0, 0);
    do_cycle(1, 0, 0, 0, 0, 0, 0);
    n_total++;
    if (fq_full !== 1'b0)
      $display("FAIL queue_cleared got full=%b expected 0", fq_full);
    else n_pass++;
    // Drain the two not-taken entries, then check the +4 wrap.
    do_cycle(0, 0, 0, 1, 32'h20, 0, 0);
    do_cycle(1, 1, 32'h44, 1, 32'h24, 0, 0);
    do_cycle(0, 0, 0, 1, 32'hFFFFFFFC, 0, 0);
    n_total++;
    if ({redirect, redirect_pc} !== {exp_redirect, exp_redirect_pc} || redirect_pc !== 32'h0)
      $display("FAIL pc_wrap got redir=%b rpc=%h expected 1 00000000", redirect, redirect_pc);
    else n_pass++;
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) do_cycle(1, 1, 32'h1000 + i * 4, 0, 0, 0, 0);
    n_total++;
    if (fq_full !== 1'b1) $display("FAIL full_after_fill got %b expected 1", fq_full);
    else n_pass++;
    do_cycle(1, 1, 32'hDEAD0000, 0, 0, 0, 0);
    do_cycle(1, 1, 32'h2000, 1, 32'h50, 1, 32'h1000);
    n_total++;
    if ({fq_full, redirect, btb_target} !== {1'b1, 1'b0, 32'h1000})
      $display("FAIL full_push_pop got full=%b redir=%b tgt=%h expected 1 0 1000",
               fq_full, redirect, btb_target);
    else n_pass++;
    for (int r = 0; r < 3; r++) begin
      while (mq.size() > 0) begin
        do_cycle(0, 0, 0, 1, 32'h60, 1, mq[0].target);
        n_total++;
        if ({redirect, btb_target} !== {1'b0, exp_btb_target})
          $display("FAIL drain_order round %0d got redir=%b tgt=%h expected 0 %h",
                   r, redirect, btb_target, exp_btb_target);
        else n_pass++;
      end
      for (int i = 0; i < 4; i++) do_cycle(1, 1, $urandom & 32'hFFFFFFFC, 0, 0, 0, 0);
    end
  endtask

  task automatic test_mismatch_push();
    while (mq.size() > 0) do_cycle(0, 0, 0, 1, 32'h70, 1, mq[0].target);
    do_cycle(1, 1, 32'h500, 0, 0, 0, 0);
    do_cycle(1, 1, 32'h600, 1, 32'h90, 1, 32'h504);
    n_total++;
    if ({redirect, redirect_pc, btb_update, btb_target, fq_full} !==
        {1'b1, 32'h504, 1'b1, 32'h504, 1'b0})
      $display("FAIL mismatch_push got redir=%b rpc=%h upd=%b tgt=%h full=%b expected 1 504 1 504 0",
               redirect, redirect_pc, btb_update, btb_target, fq_full);
    else n_pass++;
    do_cycle(0, 0, 0, 1, 32'hA0, 1, 32'h600);
    n_total++;
    if (redirect !== 1'b1)
      $display("FAIL push_discarded got redir=%b expected 1", redirect);
    else n_pass++;
  endtask

  task automatic test_random();
    logic p, ptk, ev, tk;
    logic [31:0] ptg, pc, tg;
    for (int i = 0; i < 400; i++) begin
      p   = ($urandom_range(0, 2) != 0);
      ptk = $urandom_range(0, 1);
      ptg = $urandom_range(0, 15) << 2;
      ev  = ($urandom_range(0, 2) == 0);
      tk  = $urandom_range(0, 1);
      pc  = $urandom & 32'hFFFFFFFC;
      tg  = (mq.size() > 0 && $urandom_range(0, 3) != 0) ? mq[0].target
                                                         : ($urandom_range(0, 15) << 2);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) tk = mq[0].taken;
      do_cycle(p, ptk, ptg, ev, pc, tk, tg);
      n_total++;
      if ({btb_update, btb_pc, btb_target, redirect, redirect_pc, mispredict_cnt, fq_full} !==
          {exp_btb_update, exp_btb_pc, exp_btb_target, exp_redirect, exp_redirect_pc,
           exp_cnt16, mq.size() == 4})
        $display("FAIL random cycle %0d got %h expected %h", i,
                 {btb_update, btb_pc, btb_target, redirect, redirect_pc, mispredict_cnt, fq_full},
                 {exp_btb_update, exp_btb_pc, exp_btb_target, exp_redirect, exp_redirect_pc,
                  exp_cnt16, mq.size() == 4});
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 65537; i++) do_cycle(0, 0, 0, 1, 32'hC0, 1, 32'h800);
    n_total++;
    if (mispredict_cnt !== 16'hFFFF || exp_cnt16 !== 16'hFFFF)
      $display("FAIL saturation got %h expected ffff", mispredict_cnt);
    else n_pass++;
    do_cycle(1, 1, 32'h40, 1, 32'hC4, 1, 32'h804);
    n_total++;
    if (mispredict_cnt !== 16'hFFFF)
      $display("FAIL saturation_hold got %h expected ffff", mispredict_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_cycle(1, 1, 32'h900, 0, 0, 0, 0);
    rst = 0; fq_push = 1; ex_valid = 1; ex_taken = 1; ex_pc = 32'hE0; ex_target = 32'h123;
    @(posedge clk); #1;
    rst = 1; fq_push = 0; ex_valid = 0;
    model_reset();
    n_total++;
    if ({btb_update, redirect, btb_pc, btb_target, redirect_pc, mispredict_cnt, fq_full} !== '0)
      $display("FAIL reset_mid got %h expected 0",
               {btb_update, redirect, btb_pc, btb_target, redirect_pc, mispredict_cnt, fq_full});
    else n_pass++;
    do_cycle(0, 0, 0, 1, 32'hF0, 0, 0);
    n_total++;
    if (redirect !== 1'b0)
      $display("FAIL reset_cleared_queue got redir=%b expected 0", redirect);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_correct_taken();
    test_empty_mispredict();
    test_not_taken_mispredict();
    test_full();
    test_mismatch_push();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
